// File: rtl/reg_dump_pkg.sv
// Shared constants, FSM state type and helpers for the register-dump UART transmitter.
package reg_dump_pkg;

  localparam int NUM_REGS             = 32;
  localparam int BYTES_PER_REG        = 4;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } dump_state_e;

  // Debug view: sequencer state and serializer line state side by side.
  typedef struct packed {
    dump_state_e ctrl;
    dump_state_e line;
  } dump_dbg_t;

  // Byte idx of a word, idx 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_tx_if.sv
// Register-file read port, dump control and serial line of the register dumper.
interface reg_dump_tx_if;
  logic        start;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, rd_data, input rd_reg, tx, busy, done);
  modport slave  (input start, rd_data, output rd_reg, tx, busy, done);
endinterface

// File: rtl/reg_dump_tx_uart.sv
// UART 8N1 byte serializer with a valid/ready byte input and a registered tx line.
// Handshake: a byte transfers on a cycle where valid && ready; ready is high in IDLE
// and in the last cycle of the stop bit, so consecutive bytes leave with no gap.
module uart_tx_byte
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        valid,
  output logic        ready,
  output logic        tx,
  output logic        bit_tick,
  output logic        last_bit,
  output dump_state_e line_state
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  dump_state_e state, state_nx;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tx_nx;

  assign bit_tick   = (state != IDLE) && (baud_cnt == BAUD_MAX);
  assign last_bit   = (bit_idx == 3'd7);
  assign ready      = (state == IDLE) || ((state == STOP) && bit_tick);
  assign line_state = state;

  always_comb begin
    state_nx = state;
    tx_nx    = tx;
    case (state)
      IDLE:    if (valid) state_nx = START;
      START:   if (bit_tick) state_nx = DATA;
      DATA:    if (bit_tick && last_bit) state_nx = STOP;
      STOP:    if (bit_tick) state_nx = valid ? START : IDLE;
      default: state_nx = IDLE;
    endcase
    // tx is the registered image of the next state's line level.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA: begin
        if (state == START) tx_nx = shreg[0];
        else if (bit_tick)  tx_nx = shreg[1];
      end
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nx;
      tx       <= tx_nx;
      baud_cnt <= ((state == IDLE) || bit_tick) ? '0 : baud_cnt + 16'd1;
      if ((state == DATA) && bit_tick) bit_idx <= bit_idx + 3'd1;
      else if (state != DATA)          bit_idx <= '0;
      if (valid && ready)                   shreg <= byte_in;
      else if ((state == DATA) && bit_tick) shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Dumps all 32 registers of a register file over UART, MSB first, one 32-bit
// snapshot per register taken in LOAD.
module reg_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_dump_tx_if.slave bus,
  output dump_dbg_t   dbg
);

  localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_REG - 1);

  dump_state_e state, state_nx, line_state;
  logic [4:0]  reg_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic        done_q;
  logic        byte_valid, byte_ready, bit_tick, last_bit, line_tx;
  logic [7:0]  byte_data;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_data),
    .valid      (byte_valid),
    .ready      (byte_ready),
    .tx         (line_tx),
    .bit_tick   (bit_tick),
    .last_bit   (last_bit),
    .line_state (line_state)
  );

  always_comb begin
    state_nx   = state;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state)
      IDLE: if (bus.start) state_nx = LOAD;
      // Byte 0 comes straight from rd_data: it is the value being captured.
      LOAD: begin
        byte_valid = 1'b1;
        byte_data  = word_byte(bus.rd_data, 2'd0);
        if (byte_ready) state_nx = START;
      end
      START: if (bit_tick) state_nx = DATA;
      DATA:  if (bit_tick && last_bit) state_nx = STOP;
      STOP: begin
        if (bit_tick) begin
          if (byte_idx != LAST_BYTE) begin
            byte_valid = 1'b1;
            byte_data  = word_byte(word_buf, byte_idx + 2'd1);
            state_nx   = START;
          end else if (reg_idx != LAST_REG) begin
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reg_idx  <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == STOP) && (state_nx == IDLE);
      if (state == LOAD) begin
        word_buf <= bus.rd_data;
        byte_idx <= '0;
      end else if ((state == STOP) && (state_nx == START)) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if ((state == STOP) && (state_nx == LOAD)) reg_idx <= reg_idx + 5'd1;
      else if (state_nx == IDLE)                 reg_idx <= '0;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.tx     = line_tx;
  assign bus.rd_reg = (state == IDLE) ? 5'd0 : reg_idx;
  assign dbg.ctrl   = state;
  assign dbg.line   = line_state;

endmodule

// File: doc/reg_dump_tx.md
REG_DUMP_TX -- requirements
Module: reg_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clk cycles per UART bit (434 gives 115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: asynchronous and active-low.
REQ-004 Port start, input, 1, SHALL request one full register-file dump when sampled high in IDLE.
REQ-005 Port rd_reg, output, 5, SHALL be the register-file read address (drives read_reg port of the register file).
REQ-006 Port rd_data, input, 32, SHALL be the combinational register-file read data for rd_reg, valid in the same cycle.
REQ-007 Port tx, output, 1, SHALL be the UART 8N1 serial line, idle high.
REQ-008 Port busy, output, 1, SHALL be high whenever a dump is in progress.
REQ-009 Port done, output, 1, SHALL pulse high for exactly one cycle when a dump completes.

Function
REQ-010 A dump SHALL transmit registers 0..31 in ascending order, 4 bytes per register, most significant byte first (128 bytes total).
REQ-011 Each byte SHALL be framed as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, LOAD, START, DATA, STOP; IDLE->LOAD on start; LOAD->START after 1 cycle; START->DATA; DATA->STOP after bit 7; STOP->START if bytes remain in current word, STOP->LOAD if more registers remain, STOP->IDLE after byte 3 of register 31.
REQ-013 In LOAD, rd_data SHALL be captured into a 32-bit word buffer; rd_reg SHALL equal the current register index in every state and 0 in IDLE.
REQ-014 The word buffer SHALL NOT change between LOADs; register-file writes after capture do not affect the bytes being sent.
REQ-015 busy SHALL rise the cycle after start is sampled in IDLE and fall in the same cycle done pulses.
REQ-016 done SHALL assert in the cycle the FSM returns to IDLE, after the last stop bit has been held CLKS_PER_BIT cycles.
REQ-017 Total dump duration from busy rise to done SHALL be 32*(1 + 40*CLKS_PER_BIT) cycles exactly.
REQ-018 start SHALL be ignored while busy; start held high continuously SHALL launch a new dump the cycle after done (back-to-back).
REQ-019 tx SHALL be driven from a register (glitch-free); tx SHALL be 1 in IDLE and LOAD.
REQ-020 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; register index SHALL be 5 bits, byte index 2 bits, bit index 3 bits, none exceeding range.

Reset
REQ-021 On rst_n low, at any time including mid-byte, the FSM SHALL enter IDLE immediately with tx=1, busy=0, done=0, rd_reg=0, all counters and word buffer cleared.
REQ-022 After rst_n deasserts, no transmission SHALL occur until start is sampled high in IDLE; no partial byte resumes.

Structure
REQ-023 Shared package reg_dump_pkg SHALL hold NUM_REGS=32, BYTES_PER_REG=4, the FSM state type, and the default CLKS_PER_BIT.
REQ-024 Byte serialization (START/DATA/STOP timing) SHALL be a sub-module uart_tx_byte with byte_in/valid/ready handshake; reg_dump_tx sequences registers and bytes.

Verification (CLKS_PER_BIT=4, bench model of register file with regs[i]=32'h1000_0000+i, reg 0 = 0)
REQ-025 Start pulse from IDLE -> UART monitor decodes 128 bytes: 00 00 00 00, 10 00 00 01, ..., 10 00 00 1F; done one pulse.
REQ-026 Measure busy high interval -> exactly 32*(1+160)=5152 cycles; tx each bit exactly 4 cycles.
REQ-027 Start pulses during busy (e.g., at cycle 100 and 3000) -> no effect; single 128-byte stream, one done.
REQ-028 Bench writes reg 5 = 32'hDEADBEEF while register 5 byte 1 is on the line -> reg 5 sent as 10 00 00 05; reg 5 in next dump sent as DE AD BE EF.
REQ-029 rst_n low mid data bit of register 12 -> same-cycle tx=1, busy=0; after release, tx stays 1 for 1000 cycles without start.
REQ-030 start held high through two dumps -> done pulses twice, second busy rises cycle after first done, 256 bytes decoded correctly.
